timer_irq_source: RTL and testbench

Memory-mapped countdown timer that is the interrupt source feeding the coprocessor's hardware interrupt line (one bit of its six-bit interrupt input). Software programs a preset and control word over the bridge. The block counts down, raises a level interrupt, and clears it when the coprocessor's interrupt-accepted strobe comes back or software rewrites CTRL. It sits on the system bridge beside the other peripherals.

---
 rtl/timer_irq_source_pkg.sv | 13 +
 rtl/timer_irq_source_if.sv | 11 +
 rtl/timer_irq_source.sv | 75 +++++++
 tb/tb_timer_irq_source.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/timer_irq_source_pkg.sv
// timer_pkg: shared register map, CTRL bit positions, mode encodings and FSM states for timer_irq_source.
package timer_pkg;
    localparam logic [1:0] CTRL_ADDR   = 2'd0;
    localparam logic [1:0] PRESET_ADDR = 2'd1;
    localparam logic [1:0] COUNT_ADDR  = 2'd2;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} timer_state_t;
endpackage

// File: rtl/timer_irq_source_if.sv
// timer_irq_source_if: bridge register port plus interrupt request/accept pair.
interface timer_irq_source_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_ack;
    logic        irq;
    modport master(output addr, we, wdata, int_ack, input rdata, irq);
    modport slave(input addr, we, wdata, int_ack, output rdata, irq);
endinterface

// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped countdown timer driving a level interrupt.
// Auto-reload mode is built only when TIMER_AUTO_RELOAD_EN is defined.
module timer_irq_source
    import timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int IRQ_IDX = 2
) (
    input  logic clk,
    input  logic reset_n,
    timer_irq_source_if.slave bus
);
    if (IRQ_IDX < 0 || IRQ_IDX > 5) begin : g_bad_irq_idx
        $error("IRQ_IDX must select one of six HWInt bits");
    end
    timer_state_t     state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d, ctrl_wval;
    logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
    logic             pend_q, pend_d, set_pend, reload, ctrl_wr, preset_wr, en;
`ifdef TIMER_AUTO_RELOAD_EN
    assign ctrl_wval = bus.wdata[3:0];
    assign reload    = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
`else
    assign ctrl_wval = {bus.wdata[CTRL_IM], MODE_ONESHOT & bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO], bus.wdata[CTRL_EN]};
    assign reload    = 1'b0;
`endif
    assign en        = ctrl_q[CTRL_EN];
    assign ctrl_wr   = bus.we && bus.addr == CTRL_ADDR;
    assign preset_wr = bus.we && bus.addr == PRESET_ADDR;
    assign bus.irq   = pend_q & ctrl_q[CTRL_IM];
    assign bus.rdata = bus.addr == CTRL_ADDR   ? 32'(ctrl_q)   :
                       bus.addr == PRESET_ADDR ? 32'(preset_q) :
                       bus.addr == COUNT_ADDR  ? 32'(count_q)  : '0;
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        count_d  = count_q;
        set_pend = 1'b0;
        case (state_q)
            IDLE: state_d = en ? LOAD : IDLE;
            LOAD: begin
                state_d = en ? CNT : IDLE;
                count_d = en ? preset_q : count_q;
            end
            CNT: begin
                state_d  = !en ? IDLE : count_q == '0 ? INT : CNT;
                set_pend = en && count_q == '0;
                count_d  = en && count_q != '0 ? count_q - CNT_W'(1) : count_q;
            end
            default: begin
                state_d         = reload ? LOAD : IDLE;
                ctrl_d[CTRL_EN] = reload;
            end
        endcase
        // A CPU write to CTRL overrides the hardware En clear on the same edge
        ctrl_d   = ctrl_wr ? ctrl_wval : ctrl_d;
        preset_d = preset_wr ? bus.wdata[CNT_W-1:0] : preset_q;
        pend_d   = set_pend | (pend_q & ~(bus.int_ack | ctrl_wr));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end
endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source: scoreboard bench for timer_irq_source (both TIMER_AUTO_RELOAD_EN builds).
module tb_timer_irq_source;
    import timer_pkg::*;
    localparam logic [2:0] K_CTRL = 3'd0, K_PRE = 3'd1, K_CNT = 3'd2, K_RSV = 3'd3, K_IRQ = 3'd4;
    typedef struct {
        string       tag;
        logic [2:0]  kind;
        logic [31:0] val;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    timer_irq_source_if bus();
    timer_irq_source #(.CNT_W(32), .IRQ_IDX(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #10 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic expect_v(input string tag, input logic [2:0] kind, input logic [31:0] val);
        sb.push_back('{tag, kind, val});
    endtask
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == K_IRQ) check(e.tag, {31'd0, bus.irq}, e.val);
            else begin
                bus.addr = e.kind[1:0];
                #1;
                check(e.tag, bus.rdata, e.val);
            end
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.wdata = d;
        bus.we = 1'b1;
        tick(1);
        bus.we = 1'b0;
    endtask
    task automatic ack();
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
    endtask
    task automatic wait_count(input logic [31:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            bus.addr = K_CNT[1:0];
            #1;
            if (bus.rdata == target) break;
            tick(1);
        end
        expect_v("wait_count", K_CNT, target);
        drain();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, want finish before 200us");
        $fatal(1);
    end
    initial begin
        bus.addr = 2'd0;
        bus.we = 1'b0;
        bus.wdata = '0;
        bus.int_ack = 1'b0;
        tick(2);
        reset_n = 1'b1;
        expect_v("rst_ctrl", K_CTRL, 0);
        expect_v("rst_pre", K_PRE, 0);
        expect_v("rst_cnt", K_CNT, 0);
        expect_v("rst_rsv", K_RSV, 0);
        expect_v("rst_irq", K_IRQ, 0);
        drain();
        // one-shot, PRESET=5, IM=1
        wr(PRESET_ADDR, 5);
        wr(CTRL_ADDR, 32'h9);
        expect_v("os_ctrl", K_CTRL, 9);
        drain();
        tick(1); expect_v("os_cnt_t1", K_CNT, 0); drain();
        tick(1); expect_v("os_cnt_t2", K_CNT, 5); drain();
        tick(5); expect_v("os_cnt_t7", K_CNT, 0); expect_v("os_irq_t7", K_IRQ, 0); drain();
        tick(1); expect_v("os_irq_t8", K_IRQ, 1); expect_v("os_ctrl_t8", K_CTRL, 9); drain();
        tick(1); expect_v("os_ctrl_t9", K_CTRL, 8); expect_v("os_irq_t9", K_IRQ, 1); drain();
        tick(3); expect_v("os_irq_hold", K_IRQ, 1); expect_v("os_cnt_hold", K_CNT, 0); drain();
        ack(); expect_v("os_irq_ack", K_IRQ, 0); drain();
        // set wins over int_ack on the CNT->INT edge, PRESET=0
        wr(PRESET_ADDR, 0);
        wr(CTRL_ADDR, 32'h9);
        bus.int_ack = 1'b1;
        tick(3);
        bus.int_ack = 1'b0;
        expect_v("col_set_wins", K_IRQ, 1); drain();
        tick(1); expect_v("col_ctrl", K_CTRL, 8); expect_v("col_irq", K_IRQ, 1); drain();
        ack(); expect_v("col_ack", K_IRQ, 0); drain();
        // CPU CTRL write on the one-shot En-clear edge wins
        wr(CTRL_ADDR, 32'h9);
        tick(3); expect_v("cpu_irq_t3", K_IRQ, 1); drain();
        wr(CTRL_ADDR, 32'h9);
        expect_v("cpu_ctrl_wins", K_CTRL, 9); expect_v("cpu_irq_clr", K_IRQ, 0); drain();
        tick(3); expect_v("cpu_irq_t7", K_IRQ, 1); drain();
        tick(1); expect_v("cpu_ctrl_t8", K_CTRL, 8); drain();
        ack(); expect_v("cpu_ack", K_IRQ, 0); drain();
        // masked interrupt
        wr(CTRL_ADDR, 32'h1);
        tick(3); expect_v("mask_irq_t3", K_IRQ, 0); drain();
        tick(1); expect_v("mask_ctrl_t4", K_CTRL, 0); expect_v("mask_irq_t4", K_IRQ, 0); drain();
        // PRESET write mid-count, then disable
        wr(PRESET_ADDR, 20);
        wr(CTRL_ADDR, 32'h9);
        tick(6); expect_v("mid_cnt16", K_CNT, 16); drain();
        wr(PRESET_ADDR, 3);
        expect_v("mid_cnt15", K_CNT, 15); expect_v("mid_pre3", K_PRE, 3); drain();
        tick(4); expect_v("mid_cnt11", K_CNT, 11); drain();
        wr(CTRL_ADDR, 32'h8);
        expect_v("dis_cnt_t12", K_CNT, 10); expect_v("dis_ctrl", K_CTRL, 8); drain();
        tick(1); expect_v("dis_cnt_t13", K_CNT, 10); drain();
        tick(5); expect_v("dis_cnt_hold", K_CNT, 10); expect_v("dis_irq", K_IRQ, 0); drain();
        wr(CTRL_ADDR, 32'h9);
        tick(2); expect_v("new_pre_load", K_CNT, 3); drain();
        tick(3); expect_v("new_cnt0", K_CNT, 0); expect_v("new_irq0", K_IRQ, 0); drain();
        tick(1); expect_v("new_irq1", K_IRQ, 1); drain();
        ack(); expect_v("new_ack", K_IRQ, 0); drain();
        // mode bits: auto-reload when built, forced one-shot otherwise
        wr(PRESET_ADDR, 2);
        wr(CTRL_ADDR, 32'hB);
`ifdef TIMER_AUTO_RELOAD_EN
        expect_v("ar_ctrl", K_CTRL, 32'hB); drain();
        tick(5);
        for (int k = 0; k < 3; k++) begin
            expect_v("ar_irq", K_IRQ, 1); expect_v("ar_ctrl_int", K_CTRL, 32'hB); drain();
            ack(); expect_v("ar_ack", K_IRQ, 0); drain();
            tick(1); expect_v("ar_reload", K_CNT, 2); drain();
            tick(2); expect_v("ar_cnt0", K_CNT, 0); expect_v("ar_irq0", K_IRQ, 0); drain();
            tick(1);
        end
        wr(CTRL_ADDR, 32'h8);
        expect_v("ar_stop_irq", K_IRQ, 0); drain();
`else
        expect_v("mo_ctrl", K_CTRL, 32'h9); drain();
        tick(5); expect_v("mo_irq", K_IRQ, 1); drain();
        tick(1); expect_v("mo_en_clr", K_CTRL, 32'h8); drain();
        tick(2); expect_v("mo_no_reload", K_CNT, 0); expect_v("mo_irq_hold", K_IRQ, 1); drain();
        ack(); expect_v("mo_ack", K_IRQ, 0); drain();
`endif
        // asynchronous reset mid-count
        wr(PRESET_ADDR, 10);
        wr(CTRL_ADDR, 32'h9);
        wait_count(4, 30);
        reset_n = 1'b0;
        #1;
        expect_v("ar_rst_ctrl", K_CTRL, 0);
        expect_v("ar_rst_pre", K_PRE, 0);
        expect_v("ar_rst_cnt", K_CNT, 0);
        expect_v("ar_rst_irq", K_IRQ, 0);
        drain();
        tick(2);
        reset_n = 1'b1;
        tick(3);
        expect_v("post_rst_cnt", K_CNT, 0); expect_v("post_rst_ctrl", K_CTRL, 0); expect_v("post_rst_irq", K_IRQ, 0);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
